// File: rtl/alu_logic_pkg.sv
// Shared constants for the logic-operation lane of the ALU datapath.
// Opcode encoding and perf counter width used by alu_logic_pipe and alu_logic_core.
package alu_logic_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NAND   = 3'd3;
    localparam logic [2:0] OP_NOR    = 3'd4;
    localparam logic [2:0] OP_XNOR   = 3'd5;
    localparam logic [2:0] OP_PASS_A = 3'd6;
    localparam logic [2:0] OP_NOT_A  = 3'd7;

    localparam int PERF_W = 16;

endpackage

// File: rtl/alu_logic_core.sv
// Combinational bitwise operation decode with zero and parity flag generation.
// Operand B is don't-care for PASS_A and NOT_A.
module alu_logic_core
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o,
    output logic             parity_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_AND:    y_o = a_i & b_i;
            OP_OR:     y_o = a_i | b_i;
            OP_XOR:    y_o = a_i ^ b_i;
            OP_NAND:   y_o = ~(a_i & b_i);
            OP_NOR:    y_o = ~(a_i | b_i);
            OP_XNOR:   y_o = ~(a_i ^ b_i);
            OP_PASS_A: y_o = a_i;
            OP_NOT_A:  y_o = ~a_i;
            default:   y_o = '0;
        endcase
    end

    assign zero_o   = (y_o == '0);
    assign parity_o = ^y_o;

endmodule

// File: rtl/alu_logic_pipe.sv
// Registered logic-operation lane: handshaked operands, DEPTH-entry result queue.
// Optional perf counter of completed output transfers when ALU_LOGIC_PERF_EN is defined.
module alu_logic_pipe
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity
`ifdef ALU_LOGIC_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = WIDTH + 2;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [ENT_W-1:0] ENT_RESET = {{WIDTH{1'b0}}, 1'b1, 1'b0};

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    logic [WIDTH-1:0] core_y;
    logic             core_zero;
    logic             core_parity;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [ENT_W-1:0] last_q, last_d;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] out_ent;
    logic             push;
    logic             pop;

    // Assert immediately, release two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    alu_logic_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (in_op),
        .a_i      (in_a),
        .b_i      (in_b),
        .y_o      (core_y),
        .zero_o   (core_zero),
        .parity_o (core_parity)
    );

    assign in_ready  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = head;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= ENT_RESET;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {core_y, core_zero, core_parity};
            end
        end
    end

    // When empty, the outputs keep showing the most recently popped entry.
    assign out_ent    = out_valid ? head : last_q;
    assign out_y      = out_ent[ENT_W-1:2];
    assign out_zero   = out_ent[1];
    assign out_parity = out_ent[0];

`ifdef ALU_LOGIC_PERF_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (perf_clr) begin
            perf_d = '0;
        end else if (pop && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Directed self-checking bench for alu_logic_pipe (WIDTH=4, DEPTH=2) with a result scoreboard.
// Perf counter steps are included when ALU_LOGIC_PERF_EN is defined.
module tb_alu_logic_pipe;
    import alu_logic_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;
    logic       out_zero;
    logic       out_parity;
`ifdef ALU_LOGIC_PERF_EN
    logic        perf_clr;
    logic [15:0] perf_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [5:0] exp_q[$];
    logic [5:0] drv_exp;

    logic [3:0] y_tab [8] = '{4'h2, 4'h7, 4'h5, 4'hD, 4'h8, 4'hA, 4'h6, 4'h9};
    logic       p_tab [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    alu_logic_pipe #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_parity (out_parity)
`ifdef ALU_LOGIC_PERF_EN
        ,
        .perf_clr   (perf_clr),
        .perf_count (perf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] pack(input logic [3:0] y);
        return {y, (y == 4'h0), ^y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [5:0] e);
        in_op   = op;
        in_a    = a;
        in_b    = b;
        drv_exp = e;
    endtask

    // Decide the upcoming edge's handshakes at the falling edge, then step past the rising edge.
    task automatic cycle(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("stale_pop", 32'(out_valid), 32'd0);
            end else begin
                chk("pop_data", 32'({out_y, out_zero, out_parity}), 32'(exp_q.pop_front()));
            end
        end
        if (acc) exp_q.push_back(drv_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int n;
        logic [3:0] bv [2] = '{4'hA, 4'hC};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_op     = OP_AND;
        in_a      = 4'h0;
        in_b      = 4'h0;
        drv_exp   = '0;
`ifdef ALU_LOGIC_PERF_EN
        perf_clr  = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_out_parity", 32'(out_parity), 32'd0);
`ifdef ALU_LOGIC_PERF_EN
        chk("rst_perf", 32'(perf_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // AND sweep with streaming output
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 2; j++) begin
            for (int a = 0; a < 16; a++) begin
                drive(OP_AND, 4'(a), bv[j], pack(4'(a) & bv[j]));
                cycle(acc);
                chk("sweep_accept", 32'(acc), 32'd1);
                chk("sweep_latency", 32'(out_valid), 32'd1);
                chk("sweep_y_direct", 32'(out_y), 32'(4'(a) & bv[j]));
            end
        end
        drive(OP_AND, 4'hF, 4'hA, pack(4'hA));
        cycle(acc);
        chk("fa_y", 32'(out_y), 32'hA);
        chk("fa_zero", 32'(out_zero), 32'd0);
        chk("fa_parity", 32'(out_parity), 32'd0);
        drive(OP_AND, 4'h5, 4'hA, pack(4'h0));
        cycle(acc);
        chk("5a_y", 32'(out_y), 32'h0);
        chk("5a_zero", 32'(out_zero), 32'd1);
        in_valid = 1'b0;
        cycle(acc);
        chk("sweep_drained", 32'(out_valid), 32'd0);
        chk("empty_hold_y", 32'(out_y), 32'h0);
        chk("empty_hold_zero", 32'(out_zero), 32'd1);

        // All eight opcodes, expectations from a fixed table
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 4'h6, 4'h3, {y_tab[i], (y_tab[i] == 4'h0), p_tab[i]});
            cycle(acc);
            chk("op_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        cycle(acc);
        chk("op_drained", 32'(out_valid), 32'd0);

        // Backpressure: fill the queue, hold the third beat, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(OP_XOR, 4'h1, 4'h2, pack(4'h3));
        cycle(acc);
        chk("bp_acc1", 32'(acc), 32'd1);
        drive(OP_OR, 4'h4, 4'h8, pack(4'hC));
        cycle(acc);
        chk("bp_acc2", 32'(acc), 32'd1);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        drive(OP_PASS_A, 4'h7, 4'h0, pack(4'h7));
        cycle(acc);
        chk("bp_held", 32'(acc), 32'd0);
        chk("bp_head_stable", 32'(out_y), 32'h3);
        out_ready = 1'b1;
        cycle(acc);
        chk("bp_full_refuse_on_pop", 32'(acc), 32'd0);
        cycle(acc);
        chk("bp_third_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (out_valid && n < 10) begin
            cycle(acc);
            n++;
        end
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Continuous push/pop at count=1
        in_valid = 1'b1;
        drive(OP_NAND, 4'h0, 4'h0, pack(4'hF));
        cycle(acc);
        for (int i = 1; i <= 10; i++) begin
            drive(OP_XNOR, 4'(i), 4'(3 * i), pack(~(4'(i) ^ 4'(3 * i))));
            cycle(acc);
            chk("stream_accept", 32'(acc), 32'd1);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        cycle(acc);
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset with two entries queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(OP_NOT_A, 4'h2, 4'h0, pack(4'hD));
        cycle(acc);
        drive(OP_NOR, 4'h1, 4'h2, pack(4'hC));
        cycle(acc);
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_y", 32'(out_y), 32'd0);
        chk("arst_out_zero", 32'(out_zero), 32'd1);
        exp_q.delete();
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) cycle(acc);
        chk("post_rst_empty", 32'(out_valid), 32'd0);
        chk("post_rst_ready", 32'(in_ready), 32'd1);

`ifdef ALU_LOGIC_PERF_EN
        chk("perf_after_rst", 32'(perf_count), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(OP_PASS_A, 4'(i + 1), 4'h0, pack(4'(i + 1)));
            cycle(acc);
        end
        in_valid = 1'b0;
        cycle(acc);
        chk("perf_five", 32'(perf_count), 32'd5);

        in_valid = 1'b1;
        drive(OP_OR, 4'h1, 4'h0, pack(4'h1));
        cycle(acc);
        in_valid = 1'b0;
        perf_clr = 1'b1;
        cycle(acc);
        perf_clr = 1'b0;
        chk("perf_clr_with_pop", 32'(perf_count), 32'd0);

        in_valid = 1'b1;
        drive(OP_OR, 4'h2, 4'h0, pack(4'h2));
        cycle(acc);
        in_valid = 1'b0;
        force dut.perf_q = 16'hFFFF;
        #1;
        release dut.perf_q;
        cycle(acc);
        chk("perf_saturate", 32'(perf_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
